// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32I decode stage with a 1-entry skid buffer.
// Instructions are decoded on entry. The control bundle then sits in the output
// register, or in the skid entry while the output is stalled. Branch and jump
// types are reported here; the branch itself is resolved downstream.
// Optional feature: define RV32M_EN to decode M-extension ops (funct7=0000001).
module decode_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_inst,
  input  logic [XLEN-1:0]      i_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_pc,
  output logic [31:0]          o_inst,
  output logic                 o_insn_vld,
  output logic                 o_RegWEn,
  output logic                 o_MemRW,
  output logic                 o_Asel,
  output logic                 o_Bsel,
  output logic                 o_BrUn,
  output logic                 o_branch,
  output logic                 o_jump,
  output logic [2:0]           o_ImmSel,
  output logic [1:0]           o_WBSel,
  output logic [3:0]           o_ALUSel,
  output logic [2:0]           o_lsu_sel,
  output logic                 o_mdu_en,
  output logic [2:0]           o_mdu_op,
  output logic [ILL_CNT_W-1:0] o_ill_cnt
);

  typedef struct packed {
    logic       insn_vld;
    logic       reg_wen;
    logic       mem_rw;
    logic       a_sel;
    logic       b_sel;
    logic       br_un;
    logic       branch;
    logic       jump;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel;
    logic [3:0] alu_sel;
    logic [2:0] lsu_sel;
    logic       mdu_en;
    logic [2:0] mdu_op;
  } ctrl_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef RV32M_EN
  localparam logic [6:0] F7_MDU  = 7'b0000001;
`endif

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_AND   = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_INV   = 4'd15;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] LSU_LW  = 3'd0;
  localparam logic [2:0] LSU_SW  = 3'd1;
  localparam logic [2:0] LSU_LB  = 3'd2;
  localparam logic [2:0] LSU_LBU = 3'd3;
  localparam logic [2:0] LSU_LH  = 3'd4;
  localparam logic [2:0] LSU_LHU = 3'd5;
  localparam logic [2:0] LSU_SB  = 3'd6;
  localparam logic [2:0] LSU_SH  = 3'd7;

  // Bundle for an illegal instruction: everything 0 except the invalid ALU code
  function automatic ctrl_t illegal_ctrl();
    ctrl_t c;
    c         = '0;
    c.alu_sel = ALU_INV;
    return c;
  endfunction

  // Base-encoding ALU op shared by OP and OP-IMM
  function automatic logic [3:0] alu_by_f3(input logic [2:0] f3);
    logic [3:0] a;
    case (f3)
      3'b000:  a = ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  // Full decode of one instruction; any unrecognised encoding collapses to illegal_ctrl
  function automatic ctrl_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7);
    ctrl_t c;
    logic  ok;
    c  = '0;
    ok = 1'b1;
    case (opc)
      OPC_OP: begin
        c.reg_wen = 1'b1;
        c.wb_sel  = WB_ALU;
        if (f7 == F7_BASE) c.alu_sel = alu_by_f3(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) c.alu_sel = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) c.alu_sel = ALU_SRA;
`ifdef RV32M_EN
        else if (f7 == F7_MDU) begin
          c.mdu_en  = 1'b1;
          c.mdu_op  = f3;
          c.alu_sel = ALU_ADD;
        end
`endif
        else ok = 1'b0;
      end
      OPC_IMM: begin
        c.reg_wen = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_I;
        c.wb_sel  = WB_ALU;
        if (f3 == 3'b001) begin
          if (f7 == F7_BASE) c.alu_sel = ALU_SLL;
          else ok = 1'b0;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE) c.alu_sel = ALU_SRL;
          else if (f7 == F7_ALT) c.alu_sel = ALU_SRA;
          else ok = 1'b0;
        end else begin
          c.alu_sel = alu_by_f3(f3);
        end
      end
      OPC_LOAD: begin
        c.reg_wen = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_I;
        c.wb_sel  = WB_MEM;
        c.alu_sel = ALU_ADD;
        case (f3)
          3'b000:  c.lsu_sel = LSU_LB;
          3'b001:  c.lsu_sel = LSU_LH;
          3'b010:  c.lsu_sel = LSU_LW;
          3'b100:  c.lsu_sel = LSU_LBU;
          3'b101:  c.lsu_sel = LSU_LHU;
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        c.mem_rw  = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_S;
        c.alu_sel = ALU_ADD;
        case (f3)
          3'b000:  c.lsu_sel = LSU_SB;
          3'b001:  c.lsu_sel = LSU_SH;
          3'b010:  c.lsu_sel = LSU_SW;
          default: ok = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        c.branch  = 1'b1;
        c.a_sel   = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_B;
        c.alu_sel = ALU_ADD;
        // Unsigned compares (bltu/bgeu, funct3 11x) are the ones with br_un low
        c.br_un   = ~(f3[2] & f3[1]);
        if (f3[2:1] == 2'b01) ok = 1'b0;
      end
      OPC_JAL: begin
        c.jump    = 1'b1;
        c.reg_wen = 1'b1;
        c.a_sel   = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_J;
        c.wb_sel  = WB_PC4;
        c.alu_sel = ALU_ADD;
      end
      OPC_JALR: begin
        c.jump    = 1'b1;
        c.reg_wen = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_I;
        c.wb_sel  = WB_PC4;
        c.alu_sel = ALU_ADD;
        if (f3 != 3'b000) ok = 1'b0;
      end
      OPC_LUI: begin
        c.reg_wen = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_U;
        c.wb_sel  = WB_ALU;
        c.alu_sel = ALU_PASSB;
      end
      OPC_AUIPC: begin
        c.reg_wen = 1'b1;
        c.a_sel   = 1'b1;
        c.b_sel   = 1'b1;
        c.imm_sel = IMM_U;
        c.wb_sel  = WB_ALU;
        c.alu_sel = ALU_ADD;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) c = illegal_ctrl();
    else c.insn_vld = 1'b1;
    return c;
  endfunction

  // ---- stage p0: incoming decode and skid entry ----
  ctrl_t           in_ctrl_p0;
  ctrl_t           skid_ctrl_p0;
  logic [XLEN-1:0] skid_pc_p0;
  logic [31:0]     skid_inst_p0;
  logic            skid_vld_p0;

  // ---- stage p1: output register ----
  ctrl_t           out_ctrl_p1;
  logic [XLEN-1:0] out_pc_p1;
  logic [31:0]     out_inst_p1;
  logic            vld_p1;

  logic [ILL_CNT_W-1:0] ill_cnt;

  logic accept, out_fire, out_free, load_skid, load_in, fill_skid;

  assign in_ctrl_p0 = decode(i_inst[6:0], i_inst[14:12], i_inst[31:25]);

  // o_ready depends only on registered skid occupancy, never on i_ready
  assign o_ready   = ~skid_vld_p0;
  assign accept    = i_valid & o_ready;
  assign out_fire  = vld_p1 & i_ready;
  assign out_free  = ~vld_p1 | i_ready;
  assign load_skid = out_free & skid_vld_p0;
  assign load_in   = out_free & ~skid_vld_p0 & accept;
  assign fill_skid = ~out_free & accept;

  // Occupancy of the output register and skid entry; flush outranks everything but reset
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else begin
      if (out_free) vld_p1 <= skid_vld_p0 | accept;
      if (load_skid) skid_vld_p0 <= 1'b0;
      else if (fill_skid) skid_vld_p0 <= 1'b1;
    end
  end

  // Output register payload, refilled from the skid entry first to keep order
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_ctrl_p1 <= illegal_ctrl();
      out_pc_p1   <= '0;
      out_inst_p1 <= '0;
    end else if (!i_flush) begin
      if (load_skid) begin
        out_ctrl_p1 <= skid_ctrl_p0;
        out_pc_p1   <= skid_pc_p0;
        out_inst_p1 <= skid_inst_p0;
      end else if (load_in) begin
        out_ctrl_p1 <= in_ctrl_p0;
        out_pc_p1   <= i_pc;
        out_inst_p1 <= i_inst;
      end
    end
  end

  // Skid payload captures an instruction accepted while the output is stalled
  always_ff @(posedge i_clk) begin
    if (fill_skid) begin
      skid_ctrl_p0 <= in_ctrl_p0;
      skid_pc_p0   <= i_pc;
      skid_inst_p0 <= i_inst;
    end
  end

  // Saturating count of illegal instructions handed downstream
  always_ff @(posedge i_clk) begin
    if (i_rst) ill_cnt <= '0;
    else if (out_fire && !out_ctrl_p1.insn_vld && !(&ill_cnt)) ill_cnt <= ill_cnt + 1'b1;
  end

  assign o_valid    = vld_p1;
  assign o_pc       = out_pc_p1;
  assign o_inst     = out_inst_p1;
  assign o_insn_vld = out_ctrl_p1.insn_vld;
  assign o_RegWEn   = out_ctrl_p1.reg_wen;
  assign o_MemRW    = out_ctrl_p1.mem_rw;
  assign o_Asel     = out_ctrl_p1.a_sel;
  assign o_Bsel     = out_ctrl_p1.b_sel;
  assign o_BrUn     = out_ctrl_p1.br_un;
  assign o_branch   = out_ctrl_p1.branch;
  assign o_jump     = out_ctrl_p1.jump;
  assign o_ImmSel   = out_ctrl_p1.imm_sel;
  assign o_WBSel    = out_ctrl_p1.wb_sel;
  assign o_ALUSel   = out_ctrl_p1.alu_sel;
  assign o_lsu_sel  = out_ctrl_p1.lsu_sel;
  assign o_mdu_en   = out_ctrl_p1.mdu_en;
  assign o_mdu_op   = out_ctrl_p1.mdu_op;
  assign o_ill_cnt  = ill_cnt;

endmodule
